// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: 2^DEPTH_LOG2 x 64-bit words, INCR bursts of 8-byte beats,
// independent write (AW/W/B) and read (AR/R) state machines.
module axi_mem_slave #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              axi_aw_valid_i,
  output logic              axi_aw_ready_o,
  input  logic [ADDR_W-1:0] axi_aw_addr_i,
  input  logic [ID_W-1:0]   axi_aw_id_i,
  input  logic [7:0]        axi_aw_len_i,
  input  logic              axi_w_valid_i,
  output logic              axi_w_ready_o,
  input  logic [63:0]       axi_w_data_i,
  input  logic [7:0]        axi_w_strb_i,
  input  logic              axi_w_last_i,
  output logic              axi_b_valid_o,
  input  logic              axi_b_ready_i,
  output logic [1:0]        axi_b_resp_o,
  output logic [ID_W-1:0]   axi_b_id_o,
  input  logic              axi_ar_valid_i,
  output logic              axi_ar_ready_o,
  input  logic [ADDR_W-1:0] axi_ar_addr_i,
  input  logic [ID_W-1:0]   axi_ar_id_i,
  input  logic [7:0]        axi_ar_len_i,
  output logic              axi_r_valid_o,
  input  logic              axi_r_ready_i,
  output logic [63:0]       axi_r_data_o,
  output logic [1:0]        axi_r_resp_o,
  output logic              axi_r_last_o,
  output logic [ID_W-1:0]   axi_r_id_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] idx_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [63:0] mem_q [DEPTH];

  w_state_e    w_state_q, w_state_d;
  idx_t        w_idx_q, w_idx_d;
  logic [7:0]  w_cnt_q, w_cnt_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [ID_W-1:0] w_id_q, w_id_d;
  logic [1:0]  b_resp_q, b_resp_d;

  r_state_e    r_state_q, r_state_d;
  idx_t        r_idx_q, r_idx_d;
  logic [7:0]  r_cnt_q, r_cnt_d;
  logic [7:0]  r_len_q, r_len_d;
  logic [ID_W-1:0] r_id_q, r_id_d;
  logic [63:0] r_data_q, r_data_d;
  logic        r_last_q, r_last_d;

  // Holds the ready outputs low until the first edge after reset release.
  logic        rdy_en_q;

  idx_t        aw_idx, ar_idx, rd_idx;
  logic [63:0] rd_word;
  logic        w_we;
  logic        unused_addr_bits;

  assign aw_idx           = axi_aw_addr_i[DEPTH_LOG2+2:3];
  assign ar_idx           = axi_ar_addr_i[DEPTH_LOG2+2:3];
  assign unused_addr_bits = ^{axi_aw_addr_i, axi_ar_addr_i};

  assign axi_aw_ready_o = rdy_en_q && (w_state_q == W_IDLE);
  assign axi_w_ready_o  = (w_state_q == W_DATA);
  assign axi_b_valid_o  = (w_state_q == W_RESP);
  assign axi_b_resp_o   = b_resp_q;
  assign axi_b_id_o     = w_id_q;
  assign axi_ar_ready_o = rdy_en_q && (r_state_q == R_IDLE);
  assign axi_r_valid_o  = (r_state_q == R_DATA);
  assign axi_r_data_o   = r_data_q;
  assign axi_r_resp_o   = '0;
  assign axi_r_last_o   = r_last_q;
  assign axi_r_id_o     = r_id_q;

  assign w_we = (w_state_q == W_DATA) && axi_w_valid_i;

  // One read port: AR address while idle, next-beat pointer during a burst.
  assign rd_idx  = (r_state_q == R_IDLE) ? ar_idx : r_idx_q;
  assign rd_word = mem_q[rd_idx];

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    w_len_d   = w_len_q;
    w_id_d    = w_id_q;
    b_resp_d  = b_resp_q;
    case (w_state_q)
      W_IDLE: begin
        if (axi_aw_valid_i && axi_aw_ready_o) begin
          w_idx_d   = aw_idx;
          w_id_d    = axi_aw_id_i;
          w_len_d   = axi_aw_len_i;
          w_cnt_d   = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi_w_valid_i) begin
          w_idx_d = w_idx_q + idx_t'(1);
          w_cnt_d = w_cnt_q + 8'd1;
          if (axi_w_last_i || (w_cnt_q == w_len_q)) begin
            b_resp_d  = (axi_w_last_i && (w_cnt_q == w_len_q)) ? 2'b00 : 2'b10;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (axi_b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    r_len_d   = r_len_q;
    r_id_d    = r_id_q;
    r_data_d  = r_data_q;
    r_last_d  = r_last_q;
    case (r_state_q)
      R_IDLE: begin
        if (axi_ar_valid_i && axi_ar_ready_o) begin
          r_data_d  = rd_word;
          r_idx_d   = ar_idx + idx_t'(1);
          r_len_d   = axi_ar_len_i;
          r_id_d    = axi_ar_id_i;
          r_cnt_d   = '0;
          r_last_d  = (axi_ar_len_i == 8'd0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi_r_ready_i) begin
          if (r_last_q) begin
            r_last_d  = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_data_d = rd_word;
            r_idx_d  = r_idx_q + idx_t'(1);
            r_cnt_d  = r_cnt_q + 8'd1;
            r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q  <= 1'b0;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      w_len_q   <= '0;
      w_id_q    <= '0;
      b_resp_q  <= '0;
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      r_len_q   <= '0;
      r_id_q    <= '0;
      r_data_q  <= '0;
      r_last_q  <= 1'b0;
    end else begin
      rdy_en_q  <= 1'b1;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      w_len_q   <= w_len_d;
      w_id_q    <= w_id_d;
      b_resp_q  <= b_resp_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      r_len_q   <= r_len_d;
      r_id_q    <= r_id_d;
      r_data_q  <= r_data_d;
      r_last_q  <= r_last_d;
    end
  end

  // Storage is never reset; a read in the same cycle sees the old word.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_we && axi_w_strb_i[i]) mem_q[w_idx_q][8*i +: 8] <= axi_w_data_i[8*i +: 8];
    end
  end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning AXI address width.
REQ-002 SHALL have parameter ID_W, default 4, meaning AXI ID width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of 64-bit memory words; data width fixed at 64.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 axi_aw_valid_i / axi_aw_ready_o  in/out  1  write-address handshake.
REQ-007 axi_aw_addr_i  input  ADDR_W  write start byte address.
REQ-008 axi_aw_id_i  input  ID_W  write transaction ID.
REQ-009 axi_aw_len_i  input  8  write beats minus one.
REQ-010 axi_w_valid_i / axi_w_ready_o  in/out  1  write-data handshake.
REQ-011 axi_w_data_i  input  64  write data beat.
REQ-012 axi_w_strb_i  input  8  byte enables, bit n covers byte n.
REQ-013 axi_w_last_i  input  1  final write beat flag.
REQ-014 axi_b_valid_o / axi_b_ready_i  out/in  1  write-response handshake.
REQ-015 axi_b_resp_o  output  2  write response, 00 OKAY, 10 SLVERR.
REQ-016 axi_b_id_o  output  ID_W  echoes captured AW ID.
REQ-017 axi_ar_valid_i / axi_ar_ready_o  in/out  1  read-address handshake.
REQ-018 axi_ar_addr_i  input  ADDR_W  read start byte address.
REQ-019 axi_ar_id_i  input  ID_W  read transaction ID.
REQ-020 axi_ar_len_i  input  8  read beats minus one.
REQ-021 axi_r_valid_o / axi_r_ready_i  out/in  1  read-data handshake.
REQ-022 axi_r_data_o  output  64  read data beat.
REQ-023 axi_r_resp_o  output  2  always 00 OKAY.
REQ-024 axi_r_last_o  output  1  high on beat index == captured len.
REQ-025 axi_r_id_o  output  ID_W  echoes captured AR ID.
REQ-026 Size, burst, prot, lock, cache, qos, region and user inputs SHALL NOT be ports; every burst is INCR with 8-byte beats.

Function
REQ-027 Memory SHALL hold 2^DEPTH_LOG2 x 64-bit words; word index = addr[DEPTH_LOG2+2:3]; upper bits ignored; index wraps modulo depth per beat (+1 word per beat).
REQ-028 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; axi_aw_ready_o high only in W_IDLE; AW handshake captures addr, id, len, clears beat counter, enters W_DATA.
REQ-029 In W_DATA axi_w_ready_o SHALL be high; each W handshake writes bytes whose strb bit is 1, then increments index and counter.
REQ-030 W_DATA SHALL exit to W_RESP on the beat where w_last is high or counter == len, whichever comes first; resp = OKAY only if both coincide, else SLVERR.
REQ-031 In W_RESP axi_b_valid_o SHALL be high and b_resp/b_id stable until axi_b_ready_i; then W_IDLE, aw_ready high next cycle.
REQ-032 Read FSM SHALL have states R_IDLE, R_DATA; axi_ar_ready_o high only in R_IDLE; AR handshake captures addr, id, len; axi_r_valid_o rises the following cycle with beat 0 registered.
REQ-033 In R_DATA r_data/r_last/r_id SHALL hold while r_valid and not r_ready; each handshake loads the next beat the next cycle (one beat per cycle when r_ready held high).
REQ-034 After the r_last handshake, r_valid SHALL drop next cycle and FSM returns to R_IDLE.
REQ-035 Read and write FSMs SHALL run independently; a read beat loaded in the same cycle as a write to the same word SHALL return pre-write data.
REQ-036 len = 255 SHALL complete 256 beats with no counter overflow.

Reset
REQ-037 While rst_n low, all outputs SHALL be 0, FSMs in IDLE; ready outputs SHALL rise on the first clk edge after rst_n high; memory contents SHALL NOT be reset or cleared, and reset mid-burst keeps beats already written.

Verification
REQ-038 AW addr 0x80000008 len 3, four W beats strb 0xFF last on beat 3 -> words 1..4 written, b_resp 00, b_id echoed.
REQ-039 AR same addr len 3, r_ready held high -> r_valid 1 cycle after AR, 4 consecutive beats match written data, r_last on beat 3 only.
REQ-040 Write strb 0x0F data 0xFFFFFFFFFFFFFFFF over 0 -> readback 0x00000000FFFFFFFF.
REQ-041 len 1 with w_last on beat 0 -> b_resp 10 after 1 beat; b_valid held 5 cycles with b_ready low.
REQ-042 r_ready toggling 1/0 mid-burst -> r_data stable while stalled; rst_n low mid-read -> r_valid 0 immediately, ar_ready 1 first edge after release.
